operand_loader: RTL

Front-end stage that feeds the 4-bit magnitude comparator on the board. It captures the two operands A and B from four slide switches, one per debounced press of a load button, and presents them as stable registered buses. It also flags when a complete operand pair is ready to compare. It contains the board-level synchronisers and debouncers, so the comparator downstream only ever sees clean, glitch-free inputs.

---
 rtl/operand_loader_if.sv | 22 ++
 rtl/operand_loader.sv | 112 +++++++++++
 2 files changed

// File: rtl/operand_loader_if.sv
// rtl/operand_loader_if.sv - switch/button inputs and operand outputs of the loader
// The slave side is the loader; the master side is the board or bench driving it.
interface operand_loader_if;
    logic [3:0] sw;
    logic       btn_load;
    logic       btn_clr;
    logic [3:0] a;
    logic [3:0] b;
    logic       valid;
    logic       new_pair;
    logic [1:0] state;

    modport slave (
        input  sw, btn_load, btn_clr,
        output a, b, valid, new_pair, state
    );

    modport master (
        output sw, btn_load, btn_clr,
        input  a, b, valid, new_pair, state
    );
endinterface

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - synchronised, debounced operand A/B capture for the comparator
// Buttons are indexed 0 = load, 1 = clear throughout.
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    operand_loader_if.slave   bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        READY  = 2'b10,
        UNUSED = 2'b11
    } state_t;

    logic [3:0]    sw_m, sw_s;
    logic [1:0]    btn_m, btn_s;
    logic [1:0]    db, db_d;
    logic [CW-1:0] cnt [2];

    state_t        state_q;
    logic [3:0]    a_q, b_q;
    logic          valid_q, new_pair_q;
    logic          load_evt, clr_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_m  <= '0;
            sw_s  <= '0;
            btn_m <= '0;
            btn_s <= '0;
        end else begin
            sw_m  <= bus.sw;
            sw_s  <= sw_m;
            btn_m <= {bus.btn_clr, bus.btn_load};
            btn_s <= btn_m;
        end
    end

    // db flips on the cycle the counter would reach DEBOUNCE_CYCLES, so a
    // synchronised pulse of exactly DEBOUNCE_CYCLES cycles is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            db_d <= db;
            for (int i = 0; i < 2; i++) begin
                if (btn_s[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= btn_s[i];
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign load_evt = db[0] & ~db_d[0];
    assign clr_evt  = db[1] & ~db_d[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            valid_q    <= 1'b0;
            new_pair_q <= 1'b0;
        end else begin
            new_pair_q <= 1'b0;
            if (clr_evt || state_q == UNUSED) begin
                state_q <= WAIT_A;
                a_q     <= '0;
                b_q     <= '0;
                valid_q <= 1'b0;
            end else if (load_evt) begin
                case (state_q)
                    WAIT_A: begin
                        a_q     <= sw_s;
                        state_q <= WAIT_B;
                    end
                    WAIT_B: begin
                        b_q        <= sw_s;
                        valid_q    <= 1'b1;
                        new_pair_q <= 1'b1;
                        state_q    <= READY;
                    end
                    READY: begin
                        a_q     <= sw_s;
                        valid_q <= 1'b0;
                        state_q <= WAIT_B;
                    end
                    default: state_q <= WAIT_A;
                endcase
            end
        end
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.valid    = valid_q;
    assign bus.new_pair = new_pair_q;
    assign bus.state    = state_q;
endmodule
